// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_pkg
//  Desc     : Shared types, stall encodings and helpers for the pipeline
//             hazard/stall controller.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        MWAIT = 2'd2
    } state_t;

    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;
    localparam int STALL_WB     = 5;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_HAZ  = 6'b000111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam int CNT_W = 8;

    // x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic src_match(input logic       rd_en,
                                       input logic [4:0] src,
                                       input logic [4:0] rd);
        return rd_en && (src == rd) && (src != 5'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_detect
//  Desc     : Combinational classification of ID-stage data hazards and the
//             resulting hold length.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int LD_BR_CYCLES  = 2,
    parameter int ALU_BR_CYCLES = 1
) (
    input  logic             id_rs1_rd_en,
    input  logic             id_rs2_rd_en,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_cmp,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd_addr,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_rd_addr,
    output logic             lu_hit,
    output logic             ba_hit,
    output logic             bl_hit,
    output logic             bm_hit,
    output logic             hit,
    output logic [CNT_W-1:0] hold_n
);

    localparam logic [CNT_W-1:0] c_ld_n  = CNT_W'(LD_BR_CYCLES);
    localparam logic [CNT_W-1:0] c_alu_n = CNT_W'(ALU_BR_CYCLES);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    logic w_ex_match;
    logic w_mem_match;

    always_comb begin
        w_ex_match  = src_match(id_rs1_rd_en, id_rs1_addr, ex_rd_addr) |
                      src_match(id_rs2_rd_en, id_rs2_addr, ex_rd_addr);
        w_mem_match = src_match(id_rs1_rd_en, id_rs1_addr, mem_rd_addr) |
                      src_match(id_rs2_rd_en, id_rs2_addr, mem_rd_addr);

        lu_hit = ex_mem_read && w_ex_match;
        ba_hit = id_uses_cmp && ex_reg_write && !ex_mem_read && w_ex_match;
        bl_hit = id_uses_cmp && ex_mem_read && w_ex_match;
        bm_hit = id_uses_cmp && mem_mem_read && w_mem_match;
        hit    = lu_hit | ba_hit | bl_hit | bm_hit;

        // Several classes can hit together; the longest hold covers them all.
        hold_n = '0;
        if (lu_hit || bm_hit)
            hold_n = c_one;
        if (ba_hit && (c_alu_n > hold_n))
            hold_n = c_alu_n;
        if (bl_hit && (c_ld_n > hold_n))
            hold_n = c_ld_n;
    end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Desc     : Hazard/stall controller and redirect buffer for the 5-stage
//             pipeline. Define PIPE_CTRL_PERF_EN to add perf counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LD_BR_CYCLES  = 2,
    parameter int ALU_BR_CYCLES = 1
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int PERF_W        = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_rs1_rd_en,
    input  logic        id_rs2_rd_en,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_cmp,
    input  logic        id_branch_taken,
    input  logic [31:0] id_branch_addr,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd_addr,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_rd_addr,
    input  logic        if_stall_req,
    input  logic        mem_stall_req,
    output logic [5:0]  stall,
    output logic        flush_if_id,
    output logic        pc_redirect,
    output logic [31:0] pc_redirect_addr
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_hazard_events,
    output logic [PERF_W-1:0] perf_redirects
`endif
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    state_t           w_eval;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_pend;
    logic [31:0]      r_pend_addr;

    logic             w_hit;
    logic [CNT_W-1:0] w_hold_n;
    logic             w_lu_hit;
    logic             w_ba_hit;
    logic             w_bl_hit;
    logic             w_bm_hit;
    logic             w_haz_entry;
    logic             w_take;
    logic             w_capture;

    hazard_detect #(
        .LD_BR_CYCLES  (LD_BR_CYCLES),
        .ALU_BR_CYCLES (ALU_BR_CYCLES)
    ) u_hazard_detect (
        .id_rs1_rd_en (id_rs1_rd_en),
        .id_rs2_rd_en (id_rs2_rd_en),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_uses_cmp  (id_uses_cmp),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_rd_addr   (ex_rd_addr),
        .mem_mem_read (mem_mem_read),
        .mem_rd_addr  (mem_rd_addr),
        .lu_hit       (w_lu_hit),
        .ba_hit       (w_ba_hit),
        .bl_hit       (w_bl_hit),
        .bm_hit       (w_bm_hit),
        .hit          (w_hit),
        .hold_n       (w_hold_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The cycle that leaves MWAIT behaves exactly like the state it resumes.
    always_comb begin
        w_eval = r_state;
        if (r_state == MWAIT)
            w_eval = (r_cnt != '0) ? HOLD : IDLE;

        w_next      = w_eval;
        w_cnt_next  = r_cnt;
        stall       = STALL_NONE;
        w_haz_entry = 1'b0;

        if (mem_stall_req) begin
            stall  = STALL_MEM;
            w_next = MWAIT;
        end else begin
            case (w_eval)
                HOLD: begin
                    stall      = STALL_HAZ;
                    w_cnt_next = r_cnt - c_one;
                    w_next     = (r_cnt == c_one) ? IDLE : HOLD;
                end
                default: begin
                    if (w_hit) begin
                        stall       = STALL_HAZ;
                        w_haz_entry = 1'b1;
                        if (w_hold_n > c_one) begin
                            w_cnt_next = w_hold_n - c_one;
                            w_next     = HOLD;
                        end
                    end else if (if_stall_req) begin
                        stall = STALL_IF;
                    end
                end
            endcase
        end
    end

    // A redirect is only trusted when ID operands are valid; it is parked when
    // the PC is frozen and replayed on the first cycle the PC may move.
    always_comb begin
        w_take           = id_branch_taken && !stall[STALL_ID_EX] && !r_pend;
        pc_redirect      = 1'b0;
        pc_redirect_addr = 32'd0;
        flush_if_id      = 1'b0;
        w_capture        = 1'b0;
        if (!stall[STALL_PC]) begin
            if (r_pend) begin
                pc_redirect      = 1'b1;
                pc_redirect_addr = r_pend_addr;
                flush_if_id      = 1'b1;
            end else if (w_take) begin
                pc_redirect      = 1'b1;
                pc_redirect_addr = id_branch_addr;
                flush_if_id      = 1'b1;
            end
        end else if (w_take) begin
            w_capture = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= 1'b0;
            r_pend_addr <= 32'd0;
        end else if (w_capture) begin
            r_pend      <= 1'b1;
            r_pend_addr <= id_branch_addr;
        end else if (r_pend && !stall[STALL_PC]) begin
            r_pend      <= 1'b0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] r_perf_stall;
    logic [PERF_W-1:0] r_perf_haz;
    logic [PERF_W-1:0] r_perf_redir;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_haz   <= '0;
            r_perf_redir <= '0;
        end else begin
            if ((stall != STALL_NONE) && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 1'b1;
            if (w_haz_entry && (r_perf_haz != '1))
                r_perf_haz <= r_perf_haz + 1'b1;
            if (pc_redirect && (r_perf_redir != '1))
                r_perf_redir <= r_perf_redir + 1'b1;
        end
    end

    assign perf_stall_cycles  = r_perf_stall;
    assign perf_hazard_events = r_perf_haz;
    assign perf_redirects     = r_perf_redir;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Desc     : Directed self-checking bench for pipe_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        id_rs1_rd_en;
    logic        id_rs2_rd_en;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_uses_cmp;
    logic        id_branch_taken;
    logic [31:0] id_branch_addr;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  ex_rd_addr;
    logic        mem_mem_read;
    logic [4:0]  mem_rd_addr;
    logic        if_stall_req;
    logic        mem_stall_req;
    logic [5:0]  stall;
    logic        flush_if_id;
    logic        pc_redirect;
    logic [31:0] pc_redirect_addr;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_hazard_events;
    logic [31:0] perf_redirects;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pipe_ctrl #(
        .LD_BR_CYCLES  (2),
        .ALU_BR_CYCLES (1)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .PERF_W        (32)
`endif
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs1_rd_en     (id_rs1_rd_en),
        .id_rs2_rd_en     (id_rs2_rd_en),
        .id_rs1_addr      (id_rs1_addr),
        .id_rs2_addr      (id_rs2_addr),
        .id_uses_cmp      (id_uses_cmp),
        .id_branch_taken  (id_branch_taken),
        .id_branch_addr   (id_branch_addr),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_read      (ex_mem_read),
        .ex_rd_addr       (ex_rd_addr),
        .mem_mem_read     (mem_mem_read),
        .mem_rd_addr      (mem_rd_addr),
        .if_stall_req     (if_stall_req),
        .mem_stall_req    (mem_stall_req),
        .stall            (stall),
        .flush_if_id      (flush_if_id),
        .pc_redirect      (pc_redirect),
        .pc_redirect_addr (pc_redirect_addr)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles  (perf_stall_cycles),
        .perf_hazard_events (perf_hazard_events),
        .perf_redirects     (perf_redirects)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [5:0] st, input logic rd,
                              input logic [31:0] ad, input logic fl);
        check_val({tag, ".stall"}, 32'(stall), 32'(st));
        check_val({tag, ".redir"}, 32'(pc_redirect), 32'(rd));
        check_val({tag, ".addr"},  pc_redirect_addr, ad);
        check_val({tag, ".flush"}, 32'(flush_if_id), 32'(fl));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ex();
        ex_reg_write = 1'b0;
        ex_mem_read  = 1'b0;
        ex_rd_addr   = 5'd0;
    endtask

    task automatic clr_all();
        id_rs1_rd_en    = 1'b0;
        id_rs2_rd_en    = 1'b0;
        id_rs1_addr     = 5'd0;
        id_rs2_addr     = 5'd0;
        id_uses_cmp     = 1'b0;
        id_branch_taken = 1'b0;
        id_branch_addr  = 32'd0;
        clr_ex();
        mem_mem_read    = 1'b0;
        mem_rd_addr     = 5'd0;
        if_stall_req    = 1'b0;
        mem_stall_req   = 1'b0;
    endtask

    // ID holds a taken "beq x5,x0,target" while EX holds "lw x5".
    task automatic set_bl(input logic [31:0] target);
        ex_reg_write    = 1'b1;
        ex_mem_read     = 1'b1;
        ex_rd_addr      = 5'd5;
        id_uses_cmp     = 1'b1;
        id_rs1_rd_en    = 1'b1;
        id_rs1_addr     = 5'd5;
        id_rs2_rd_en    = 1'b1;
        id_rs2_addr     = 5'd0;
        id_branch_taken = 1'b1;
        id_branch_addr  = target;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clr_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_outs("reset", 6'b000000, 1'b0, 32'd0, 1'b0);

        // lw x5,0(x1); add x6,x5,x2
        tick();
        ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd5;
        id_rs1_rd_en = 1'b1; id_rs1_addr = 5'd1;
        id_rs2_rd_en = 1'b1; id_rs2_addr = 5'd5;
        #1;
        check_outs("lu_c1", 6'b000111, 1'b0, 32'd0, 1'b0);
        tick();
        clr_ex(); mem_mem_read = 1'b1; mem_rd_addr = 5'd5;
        #1;
        check_outs("lu_c2", 6'b000000, 1'b0, 32'd0, 1'b0);

        // x0 never forms a dependency
        tick();
        clr_all();
        ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd0;
        id_uses_cmp = 1'b1; id_rs1_rd_en = 1'b1; id_rs1_addr = 5'd0;
        #1;
        check_outs("x0", 6'b000000, 1'b0, 32'd0, 1'b0);

        // lw x5; beq x5,x0,0x100 taken
        tick();
        clr_all();
        set_bl(32'h0000_0100);
        #1;
        check_outs("bl_c1", 6'b000111, 1'b0, 32'd0, 1'b0);
        tick();
        clr_ex(); mem_mem_read = 1'b1; mem_rd_addr = 5'd5;
        #1;
        check_outs("bl_c2", 6'b000111, 1'b0, 32'd0, 1'b0);
        tick();
        mem_mem_read = 1'b0; mem_rd_addr = 5'd0;
        #1;
        check_outs("bl_c3", 6'b000000, 1'b1, 32'h0000_0100, 1'b1);
        tick();
        clr_all();
        #1;
        check_outs("bl_c4", 6'b000000, 1'b0, 32'd0, 1'b0);

        // addi x7,x0,3; bne x7,x0,0x200
        ex_reg_write = 1'b1; ex_rd_addr = 5'd7;
        id_uses_cmp = 1'b1;
        id_rs1_rd_en = 1'b1; id_rs1_addr = 5'd7;
        id_rs2_rd_en = 1'b1; id_rs2_addr = 5'd0;
        id_branch_taken = 1'b1; id_branch_addr = 32'h0000_0200;
        #1;
        check_outs("ba_c1", 6'b000111, 1'b0, 32'd0, 1'b0);
        tick();
        clr_ex(); mem_rd_addr = 5'd7;
        #1;
        check_outs("ba_c2", 6'b000000, 1'b1, 32'h0000_0200, 1'b1);

        // branch sourcing a load still in MEM: single-cycle hold
        tick();
        clr_all();
        id_uses_cmp = 1'b1; id_rs2_rd_en = 1'b1; id_rs2_addr = 5'd9;
        mem_mem_read = 1'b1; mem_rd_addr = 5'd9;
        #1;
        check_outs("bm_c1", 6'b000111, 1'b0, 32'd0, 1'b0);
        tick();
        mem_mem_read = 1'b0; mem_rd_addr = 5'd0;
        #1;
        check_outs("bm_c2", 6'b000000, 1'b0, 32'd0, 1'b0);

        // memory wait outranks fetch wait
        tick();
        clr_all();
        mem_stall_req = 1'b1; if_stall_req = 1'b1;
        #1;
        check_outs("prio", 6'b011111, 1'b0, 32'd0, 1'b0);

        // taken branch during a 3-cycle fetch wait
        tick();
        clr_all();
        if_stall_req = 1'b1; id_branch_taken = 1'b1; id_branch_addr = 32'h0000_0300;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_outs($sformatf("ifw_%0d", i), 6'b000011, 1'b0, 32'd0, 1'b0);
            tick();
        end
        if_stall_req = 1'b0;
        #1;
        check_outs("ifw_rel", 6'b000000, 1'b1, 32'h0000_0300, 1'b1);
        tick();
        clr_all();
        #1;
        check_outs("ifw_after", 6'b000000, 1'b0, 32'd0, 1'b0);

        // memory wait in the middle of a 2-cycle load-branch hold
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_bl(32'h0000_0400);
        #1;
        check_outs("mw_haz", 6'b000111, 1'b0, 32'd0, 1'b0);
        tick();
        mem_stall_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_outs($sformatf("mw_%0d", i), 6'b011111, 1'b0, 32'd0, 1'b0);
            tick();
        end
        mem_stall_req = 1'b0;
        #1;
        check_outs("mw_resume", 6'b000111, 1'b0, 32'd0, 1'b0);
        tick();
        clr_ex();
        #1;
        check_outs("mw_redir", 6'b000000, 1'b1, 32'h0000_0400, 1'b1);
        tick();
        clr_all();
        #1;
        check_outs("mw_done", 6'b000000, 1'b0, 32'd0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        check_val("perf_stall", perf_stall_cycles, 32'd6);
        check_val("perf_redir", perf_redirects, 32'd1);
        check_val("perf_haz", perf_hazard_events, 32'd1);
`endif

        // reset on the cycle that would enter HOLD
        set_bl(32'h0000_0500);
        #1;
        check_outs("rh_haz", 6'b000111, 1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clr_all();
        #1;
        check_outs("rh_after", 6'b000000, 1'b0, 32'd0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        check_val("rh_perf_stall", perf_stall_cycles, 32'd0);
        check_val("rh_perf_redir", perf_redirects, 32'd0);
        check_val("rh_perf_haz", perf_hazard_events, 32'd0);
`endif

        // reset discards a parked redirect
        tick();
        if_stall_req = 1'b1; id_branch_taken = 1'b1; id_branch_addr = 32'h0000_0600;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clr_all();
        #1;
        check_outs("rp_after", 6'b000000, 1'b0, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central hazard and stall controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Drives the shared stall[5:0] vector read by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use and branch-operand hazards against the ID-stage decode.
- Sequences multi-cycle hazard holds and memory wait states.
- Buffers a taken branch/jump redirect that arrives while the front end is frozen, so no redirect is lost.

Parameters:
- LD_BR_CYCLES, 2, stall cycles when an ID branch/JALR sources the rd of a load in EX.
- ALU_BR_CYCLES, 1, stall cycles when an ID branch/JALR sources the rd of a non-load writer in EX.
- PERF_W, 32, width of the performance counters (optional feature only).

Ports:
- clk in 1: clock, rising edge.
- rst in 1: reset, synchronous, active-high.
- id_rs1_rd_en in 1: ID reads rs1.
- id_rs2_rd_en in 1: ID reads rs2.
- id_rs1_addr in 5: ID rs1 index.
- id_rs2_addr in 5: ID rs2 index.
- id_uses_cmp in 1: ID holds a BRA or JALR opcode whose operands feed the ID comparator or adder.
- id_branch_taken in 1: ID branch/jump taken.
- id_branch_addr in 32: ID target address.
- ex_reg_write in 1: ID/EX reg_write.
- ex_mem_read in 1: ID/EX mem_read.
- ex_rd_addr in 5: ID/EX rd.
- mem_mem_read in 1: EX/MEM mem_read.
- mem_rd_addr in 5: EX/MEM rd.
- if_stall_req in 1: instruction fetch not ready.
- mem_stall_req in 1: data memory not ready.
- stall out 6: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB (always 0).
- flush_if_id out 1: replace IF/ID contents with NOP.
- pc_redirect out 1: PC must load pc_redirect_addr this cycle.
- pc_redirect_addr out 32: redirect target.

Behaviour:
- Reset: stall=0, flush_if_id=0, pc_redirect=0, pc_redirect_addr=0, state=IDLE, hold counter=0, pending redirect cleared. Reset mid-hold or mid-wait aborts everything, including any pending redirect.
- A source matches when its rd_en=1, its addr equals the producer rd, and the addr is not 0.
- Hazard classes:
  - LU (load-use): ex_mem_read and a source match ex_rd_addr.
  - BA: id_uses_cmp, ex_reg_write, not ex_mem_read, and a match on ex_rd_addr.
  - BL: id_uses_cmp and ex_mem_read and a match on ex_rd_addr.
  - BM: id_uses_cmp and mem_mem_read and a match on mem_rd_addr.
- Hold length N:
  - BL gives LD_BR_CYCLES.
  - BA gives ALU_BR_CYCLES.
  - LU and BM each give 1.
  - If several classes hit, take the maximum.
- Stall patterns:
  - MEM wait: 011111.
  - Hazard hold: 000111, which bubbles ID/EX.
  - IF wait: 000011, which bubbles IF/ID.
  - None: 000000.
- Priority: mem_stall_req > hold/hazard > if_stall_req.
- FSM states:
  - IDLE: on hazard, assert 000111 in the same cycle. If N>1, load counter=N-1 and go to HOLD. mem_stall_req takes priority and goes to MWAIT.
  - HOLD: assert 000111 regardless of the hazard inputs; decrement the counter; return to IDLE when it reaches 0. mem_stall_req moves to MWAIT and the remaining count is kept, then resumed on exit.
  - MWAIT: assert 011111 while mem_stall_req is high. On deassert, return to HOLD if count>0, else IDLE. That exit cycle re-evaluates normally.
- Redirect:
  - id_branch_taken is honoured only when stall[2]=0 (ID operands valid).
  - If honoured and stall[0]=0: pc_redirect=1, pc_redirect_addr=id_branch_addr, flush_if_id=1, all in the same cycle (combinational).
  - If honoured but stall[0]=1 (IF wait only): latch the target into the pending register. Assert pc_redirect and flush_if_id in the first cycle with stall[0]=0, then clear pending.
  - A pending redirect blocks capture of any new redirect; none can arrive, because ID is frozen.
  - id_branch_taken while stall[2]=1 is ignored.
- No outputs depend on rst other than through the synchronous reset above.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- When defined, adds outputs perf_stall_cycles [PERF_W], perf_hazard_events [PERF_W] and perf_redirects [PERF_W], all reset to 0, saturating at all-ones:
  - perf_stall_cycles increments on each cycle with stall!=0.
  - perf_hazard_events increments on each IDLE-to-hazard entry.
  - perf_redirects increments on each pc_redirect cycle.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (IDLE, HOLD, MWAIT);
  - the STALL_NONE, STALL_IF, STALL_HAZ and STALL_MEM 6-bit constants;
  - the stall bit-index localparams.
- Sub-module hazard_detect: purely combinational; outputs the hit and N for the LU/BA/BL/BM classes.

Test Plan:
- lw x5,0(x1); add x6,x5,x2 → stall=000111 for exactly 1 cycle, ID/EX bubble, add completes with the correct x6.
- lw x5; beq x5,x0,L (taken) → 2 cycles of 000111, then pc_redirect=1 with addr=L and flush_if_id=1 for 1 cycle.
- addi x7,x0,3; bne x7,x0,L → 1 cycle of 000111, then redirect to L.
- Branch taken while if_stall_req=1 for 3 cycles → no redirect during the wait; redirect to the latched target on the cycle if_stall_req falls.
- mem_stall_req high for 4 cycles during a 2-cycle BL hold → 011111 for 4 cycles, then the remaining 000111 hold resumes.
- With PIPE_CTRL_PERF_EN, after the test above → perf_stall_cycles=6, perf_redirects=1; rst mid-HOLD → all outputs 0 on the next cycle.
